// File: rtl/tdm_demux_4ch.sv
// Receive-side sequencer for an SN74LS153 4:1 selector: walks the select lines,
// samples Y once per slot and presents the four channels as a parallel word.
module tdm_demux_4ch #(
  parameter int SLOT_CYCLES = 1
) (
  input  logic       CLK,
  input  logic       CLR,
  input  logic       START,
  input  logic       CONT,
  input  logic       ABORT,
  input  logic       Y,
  output logic       A,
  output logic       B,
  output logic       G,
  output logic [3:0] Q,
  output logic       VALID,
  output logic       BUSY,
  output logic       STUCK,
  output logic [7:0] FRAMES
);
  localparam int CW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SLOT_CYCLES - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [1:0]    sel;
  logic [3:0]    shadow;

  assign {B, A} = sel;
  assign BUSY   = (state == RUN);

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      state  <= IDLE;
      cnt    <= '0;
      sel    <= 2'd0;
      shadow <= 4'd0;
      G      <= 1'b1;
      Q      <= 4'd0;
      VALID  <= 1'b0;
      STUCK  <= 1'b0;
      FRAMES <= 8'd0;
    end else begin
      VALID <= 1'b0;
      unique case (state)
        IDLE: begin
          if (START && !ABORT) begin
            state <= RUN;
            G     <= 1'b0;
            sel   <= 2'd0;
            cnt   <= '0;
            STUCK <= 1'b0;
          end else if (Y) begin
            // mux is strobed off here, so any high Y is a strobe violation
            STUCK <= 1'b1;
          end
        end
        RUN: begin
          if (ABORT) begin
            state <= IDLE;
            G     <= 1'b1;
            sel   <= 2'd0;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            cnt <= '0;
            if (sel == 2'd3) begin
              Q      <= {Y, shadow[2:0]};
              VALID  <= 1'b1;
              FRAMES <= FRAMES + 8'd1;
              sel    <= 2'd0;
              if (!CONT) begin
                state <= IDLE;
                G     <= 1'b1;
              end
            end else begin
              shadow[sel] <= Y;
              sel         <= sel + 2'd1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
